// File: rtl/gate_check_pkg.sv
// Shared types and the golden gate function for the gate vector checker.
// Operands are handled up to MAX_WIDTH bits; narrower users take the low bits.
package gate_check_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRIVE,
    ST_SETTLE,
    ST_SAMPLE,
    ST_DONE
  } state_t;

  localparam int OP_AND  = 0;
  localparam int OP_OR   = 1;
  localparam int OP_XOR  = 2;
  localparam int OP_NAND = 3;

  localparam int MAX_WIDTH = 4;

  function automatic logic golden_bit(input int op, input logic a, input logic b);
    case (op)
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      OP_NAND: return ~(a & b);
      default: return a | b;
    endcase
  endfunction

  function automatic logic [MAX_WIDTH-1:0] golden_op(input int op,
                                                     input logic [MAX_WIDTH-1:0] a,
                                                     input logic [MAX_WIDTH-1:0] b);
    logic [MAX_WIDTH-1:0] res;
    res = '0;
    for (int i = 0; i < MAX_WIDTH; i++) begin
      res[i] = golden_bit(op, a[i], b[i]);
    end
    return res;
  endfunction

endpackage

// File: rtl/gate_vector_checker_if.sv
// Stimulus/response bundle between the checker (master) and the gate under test plus control (slave).
interface gate_vector_checker_if #(
  parameter int WIDTH = 1
);
  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [WIDTH-1:0]   c;
  logic               busy;
  logic               done;
  logic               pass;
  logic [2*WIDTH:0]   err_count;
  logic               fail_valid;
  logic [2*WIDTH-1:0] fail_idx;

  modport master (
    input  start, c,
    output a, b, busy, done, pass, err_count, fail_valid, fail_idx
  );

  modport slave (
    output start, c,
    input  a, b, busy, done, pass, err_count, fail_valid, fail_idx
  );
endinterface

// File: rtl/gate_golden_model.sv
// Combinational reference gate: applies the selected two-input function bit by bit.
module gate_golden_model
  import gate_check_pkg::*;
#(
  parameter int WIDTH  = 1,
  parameter int OP_SEL = OP_OR
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] expected
);

  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    assign expected[gi] = golden_bit(OP_SEL, a[gi], b[gi]);
  end

endmodule

// File: rtl/gate_vector_checker.sv
// Sweeps every a/b combination into a two-input gate, waits a settle window,
// and compares the gate output against the golden function.
module gate_vector_checker
  import gate_check_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int SETTLE_CYCLES = 1,
  parameter int OP_SEL        = OP_OR
) (
  input logic                   clk,
  input logic                   rst_n,
  gate_vector_checker_if.master bus
);

  localparam int IW = 2 * WIDTH;
  localparam logic [IW-1:0] LAST_IDX    = {IW{1'b1}};
  localparam logic [IW-1:0] IDX_ONE     = IW'(1);
  localparam logic [IW:0]   ERR_ONE     = (IW + 1)'(1);
  localparam logic [3:0]    SETTLE_LOAD = 4'(SETTLE_CYCLES);
  localparam logic [3:0]    CNT_ONE     = 4'd1;

  state_t          state_reg;
  logic [IW-1:0]   idx_reg;
  logic [3:0]      settle_cnt_reg;
  logic [WIDTH-1:0] expected;
  logic            mismatch;

  // a is the upper half of the index so the sweep order is a-major
  assign bus.a = idx_reg[IW-1:WIDTH];
  assign bus.b = idx_reg[WIDTH-1:0];

  gate_golden_model #(
    .WIDTH  (WIDTH),
    .OP_SEL (OP_SEL)
  ) u_golden (
    .a        (bus.a),
    .b        (bus.b),
    .expected (expected)
  );

  // Case inequality so an X on the gate output counts as a failure
  assign mismatch = (bus.c !== expected);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      settle_cnt_reg <= '0;
      bus.busy       <= 1'b0;
      bus.done       <= 1'b0;
      bus.pass       <= 1'b0;
      bus.err_count  <= '0;
      bus.fail_valid <= 1'b0;
      bus.fail_idx   <= '0;
    end else begin
      bus.done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start) begin
            state_reg      <= ST_DRIVE;
            idx_reg        <= '0;
            bus.busy       <= 1'b1;
            bus.pass       <= 1'b0;
            bus.err_count  <= '0;
            bus.fail_valid <= 1'b0;
            bus.fail_idx   <= '0;
          end
        end
        ST_DRIVE: begin
          state_reg      <= ST_SETTLE;
          settle_cnt_reg <= SETTLE_LOAD;
        end
        ST_SETTLE: begin
          settle_cnt_reg <= settle_cnt_reg - CNT_ONE;
          if (settle_cnt_reg <= CNT_ONE) begin
            state_reg <= ST_SAMPLE;
          end
        end
        ST_SAMPLE: begin
          if (mismatch) begin
            bus.err_count <= bus.err_count + ERR_ONE;
            if (!bus.fail_valid) begin
              bus.fail_valid <= 1'b1;
              bus.fail_idx   <= idx_reg;
            end
          end
          if (idx_reg == LAST_IDX) begin
            state_reg <= ST_DONE;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            // Fold in this final compare so pass is valid alongside done
            bus.pass  <= (bus.err_count == '0) && !mismatch;
          end else begin
            state_reg <= ST_DRIVE;
            idx_reg   <= idx_reg + IDX_ONE;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/gate_vector_checker.md
Name: gate_vector_checker

Overview:
- Self-sequencing stimulus and check stage for two-input combinational gate blocks, such as the team's OR gate.
- Upstream side: on `start`, drives every combination of operands `a`/`b` into the gate under test, one vector at a time.
- Downstream side: samples the gate output `c` after a settle window and compares it with an internally computed golden result.
- Reports the error count and the first failing vector, and replaces hand-written `#delay` stimulus with a clocked, repeatable sweep.

Parameters:
- WIDTH, 1, operand width of `a` and `b`; legal range 1..4, so the sweep is 2^(2*WIDTH) vectors, at most 256.
- SETTLE_CYCLES, 1, cycles the vector is held before `c` is sampled; legal range 1..15.
- OP_SEL, 1, golden function, applied bitwise: 0=AND, 1=OR, 2=XOR, 3=NAND.

Ports:
- clk, input, 1, single clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, single-cycle request to begin a sweep; honoured only in IDLE.
- a, output, WIDTH, operand A to the gate under test (registered).
- b, output, WIDTH, operand B to the gate under test (registered).
- c, input, WIDTH, gate-under-test output; sampled only in SAMPLE.
- busy, output, 1, high in DRIVE, SETTLE and SAMPLE.
- done, output, 1, one-cycle pulse when a sweep completes.
- pass, output, 1, high when the last completed sweep had zero errors; held until the next accepted start.
- err_count, output, 2*WIDTH+1, number of mismatching vectors in the current or last sweep.
- fail_valid, output, 1, high once any mismatch has been recorded in the sweep.
- fail_idx, output, 2*WIDTH, vector index of the first mismatch; valid only while fail_valid is high.

Behaviour:
- Reset is asynchronous and active-low. On assertion:
  - state goes to IDLE;
  - a, b, busy, done, pass, err_count, fail_valid and fail_idx all go to 0;
  - the internal index, settle counter and settle timer clear.
- Reset mid-sweep aborts immediately. No done pulse; pass=0.
- Vector index `idx` has width 2*WIDTH:
  - a = idx[2*WIDTH-1:WIDTH], b = idx[WIDTH-1:0];
  - the sweep runs idx = 0 up to 2^(2*WIDTH)-1 with no skipping and no wrap past the last vector.
- Golden result: exp = OP_SEL function of the registered a and b, computed bitwise over WIDTH bits.
- FSM states: IDLE, DRIVE, SETTLE, SAMPLE, DONE.
  - IDLE:
    - start=1 → DRIVE.
    - On that same edge: idx, a and b load 0; err_count, fail_valid and pass clear.
    - start=0 → stay in IDLE.
  - DRIVE:
    - lasts 1 cycle while a and b are stable.
    - → SETTLE, with the settle counter loaded to SETTLE_CYCLES.
  - SETTLE:
    - counter decrements each cycle.
    - when it reaches 1 → SAMPLE, so SETTLE spans exactly SETTLE_CYCLES cycles.
  - SAMPLE:
    - compare c against exp.
    - On mismatch: err_count increments. If fail_valid=0, fail_idx is set to idx and fail_valid to 1.
    - If idx is the last vector → DONE.
    - Otherwise idx increments, a and b update on the same edge, and the state goes to DRIVE.
  - DONE:
    - done=1 for this one cycle; pass = (err_count==0) once the mismatch count is final, i.e. the last SAMPLE compare included.
    - → IDLE.
- Cycles per vector = SETTLE_CYCLES + 2. From the edge that accepts start to the edge where done rises: V*(SETTLE_CYCLES+2) cycles, where V = 2^(2*WIDTH).
- start is ignored while busy or in DONE; there is no queuing.
- start asserted in the IDLE cycle immediately after DONE is accepted normally.
- err_count cannot overflow: its maximum value is V, which fits in 2*WIDTH+1 bits.
- c is treated as combinational from a and b. Changes to c outside SAMPLE have no effect.
- Unknown values (X) on c count as mismatches; the compare uses case inequality.

Decomposition:
- Package gate_check_pkg:
  - FSM state enum;
  - OP_SEL encodings OP_AND, OP_OR, OP_XOR, OP_NAND;
  - function golden_op(op, a, b) returning WIDTH bits.
- One natural sub-module: gate_golden_model, a combinational OP_SEL function block instantiated inside the checker. Everything else stays in the top module.

Test Plan:
- Golden OR gate, defaults (WIDTH=1, SETTLE=1, OP_SEL=OR):
  - pulse start → a,b step 00,01,10,11 every 3 cycles;
  - done pulses 12 cycles after the start edge;
  - pass=1, err_count=0, fail_valid=0.
- Faulty OR whose c is stuck at 0:
  - err_count=3, fail_valid=1, fail_idx=1, pass=0.
- WIDTH=2, SETTLE_CYCLES=3 against a correct 2-bit OR:
  - 16 vectors at 5 cycles each, done at cycle 80;
  - pass=1; a,b reach 3,3 in the last vector.
- Reset mid-sweep:
  - assert rst_n=0 during the vector with idx=2 → all outputs read 0 asynchronously and no done pulse occurs;
  - restart → a full clean sweep.
- start held high for the entire sweep → exactly one sweep and one done pulse.
- start again on the cycle after done → a second sweep begins, with err_count and fail_valid cleared.
- OP_SEL=XOR checker against an OR gate:
  - only idx=3 mismatches: err_count=1, fail_idx=3, pass=0.
